// File: rtl/sevenseg_scan_ctrl.sv
// Multiplexed N-digit seven-segment scanner with frame-synchronous loading,
// leading-zero blanking, PWM dimming and a blank cycle at each digit slot start.
module sevenseg_scan_ctrl #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int DIM_W       = 3
) (
    input  logic                  ext_clk,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp,
    input  logic                  load,
    input  logic                  lz_en,
    input  logic [DIM_W-1:0]      bright,
    output logic [DIGITS-1:0]     an,
    output logic [7:0]            seg,
    output logic                  frame_tick,
    output logic                  pending
);

    localparam int SW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [SW-1:0]       slot_reg;
    logic [DW-1:0]       digit_reg;
    logic [DIM_W-1:0]    pwm_reg;
    logic [4*DIGITS-1:0] shadow_reg;
    logic [4*DIGITS-1:0] disp_reg;
    logic [DIGITS-1:0]   shadow_dp_reg;
    logic [DIGITS-1:0]   disp_dp_reg;
    logic                pending_reg;

    logic                slot_last;
    logic                frame_end;
    logic [DIGITS:0]     zero_above;
    logic [DIGITS-1:0]   blank;
    logic [6:0]          glyph [DIGITS];
    logic                digit_on;
    logic [DIGITS-1:0]   an_next;
    logic [7:0]          seg_next;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] r;
        case (n)
            4'h0: r = 7'h3F;
            4'h1: r = 7'h06;
            4'h2: r = 7'h5B;
            4'h3: r = 7'h4F;
            4'h4: r = 7'h66;
            4'h5: r = 7'h6D;
            4'h6: r = 7'h7D;
            4'h7: r = 7'h07;
            4'h8: r = 7'h7F;
            4'h9: r = 7'h6F;
            4'hA: r = 7'h77;
            4'hB: r = 7'h7C;
            4'hC: r = 7'h39;
            4'hD: r = 7'h5E;
            4'hE: r = 7'h79;
            default: r = 7'h71;
        endcase
        return r;
    endfunction

    assign slot_last  = (slot_reg == SW'(REFRESH_DIV - 1));
    assign frame_end  = slot_last && (digit_reg == DW'(DIGITS - 1));
    assign frame_tick = frame_end;
    assign pending    = pending_reg;

    always_ff @(posedge ext_clk or negedge reset) begin
        if (!reset) begin
            slot_reg  <= '0;
            digit_reg <= '0;
            pwm_reg   <= '0;
        end else begin
            pwm_reg <= pwm_reg + 1'b1;
            if (slot_last) begin
                slot_reg  <= '0;
                digit_reg <= (digit_reg == DW'(DIGITS - 1)) ? '0 : digit_reg + 1'b1;
            end else begin
                slot_reg <= slot_reg + 1'b1;
            end
        end
    end

    // Display registers only change at the frame boundary; a load landing on
    // that very cycle bypasses the shadow so it is not delayed a whole frame.
    always_ff @(posedge ext_clk or negedge reset) begin
        if (!reset) begin
            shadow_reg    <= '0;
            shadow_dp_reg <= '0;
            disp_reg      <= '0;
            disp_dp_reg   <= '0;
            pending_reg   <= 1'b0;
        end else begin
            if (load) begin
                shadow_reg    <= value;
                shadow_dp_reg <= dp;
            end
            if (frame_end && load) begin
                disp_reg    <= value;
                disp_dp_reg <= dp;
                pending_reg <= 1'b0;
            end else if (frame_end && pending_reg) begin
                disp_reg    <= shadow_reg;
                disp_dp_reg <= shadow_dp_reg;
                pending_reg <= 1'b0;
            end else if (load) begin
                pending_reg <= 1'b1;
            end
        end
    end

    assign zero_above[DIGITS] = 1'b1;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign zero_above[gi] = zero_above[gi+1] && (disp_reg[4*gi +: 4] == 4'h0);
            assign glyph[gi]      = hex7(disp_reg[4*gi +: 4]);
            if (gi == 0) begin : g_first
                assign blank[gi] = 1'b0;
            end else begin : g_rest
                assign blank[gi] = lz_en && zero_above[gi] && !disp_dp_reg[gi];
            end
        end
    endgenerate

    always_comb begin
        digit_on = (slot_reg != '0) && (pwm_reg <= bright) && !blank[digit_reg];
        an_next  = '1;
        seg_next = 8'hFF;
        if (digit_on) begin
            an_next  = ~(DIGITS'(1) << digit_reg);
            seg_next = {~disp_dp_reg[digit_reg], ~glyph[digit_reg]};
        end
    end

    always_ff @(posedge ext_clk or negedge reset) begin
        if (!reset) begin
            an  <= '1;
            seg <= 8'hFF;
        end else begin
            an  <= an_next;
            seg <= seg_next;
        end
    end

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Directed bench for sevenseg_scan_ctrl with DIGITS=4, REFRESH_DIV=4, DIM_W=2.
module tb_sevenseg_scan_ctrl;

    logic        ext_clk = 1'b0;
    logic        reset;
    logic [15:0] value;
    logic [3:0]  dp;
    logic        load;
    logic        lz_en;
    logic [1:0]  bright;
    logic [3:0]  an;
    logic [7:0]  seg;
    logic        frame_tick;
    logic        pending;

    int n_checks = 0;
    int n_errors = 0;

    sevenseg_scan_ctrl #(
        .DIGITS(4),
        .REFRESH_DIV(4),
        .DIM_W(2)
    ) dut (
        .ext_clk(ext_clk),
        .reset(reset),
        .value(value),
        .dp(dp),
        .load(load),
        .lz_en(lz_en),
        .bright(bright),
        .an(an),
        .seg(seg),
        .frame_tick(frame_tick),
        .pending(pending)
    );

    always #5 ext_clk = ~ext_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Entered just after the edge that starts scan state 0. Iteration j observes
    // outputs registered from state j (slot j%4, digit j/4); pwm equals the slot
    // because both count mod 4 from reset. Optional load is driven at iteration
    // load_at, so it is sampled during state load_at+1 (15 = frame_tick state).
    task automatic scan_frame(input string tag, input logic [31:0] exp_seg,
                              input logic [3:0] lit, input int brt, input logic lz,
                              input int load_at, input logic [15:0] lv, input logic [3:0] ldp);
        logic [3:0] ea;
        logic [7:0] es;
        logic [7:0] sel;
        bit         on;
        bright = 2'(brt);
        lz_en  = lz;
        for (int j = 0; j < 16; j++) begin
            int slot = j % 4;
            int d    = j / 4;
            @(posedge ext_clk);
            #1;
            on  = (slot != 0) && (slot <= brt) && lit[d];
            sel = exp_seg[8*d +: 8];
            ea  = 4'b0001 << d;
            ea  = on ? ~ea : 4'hF;
            es  = on ? sel : 8'hFF;
            $display("%s j=%0d an=%h seg=%h ft=%b pend=%b", tag, j, an, seg, frame_tick, pending);
            check($sformatf("%s an j=%0d", tag, j), 32'(an), 32'(ea));
            check($sformatf("%s seg j=%0d", tag, j), 32'(seg), 32'(es));
            check($sformatf("%s tick j=%0d", tag, j), 32'(frame_tick), 32'(j == 14));
            if (load_at >= 0 && j == load_at + 1) begin
                load = 1'b0;
                check($sformatf("%s pending j=%0d", tag, j), 32'(pending), 32'(load_at != 14));
            end
            if (j == load_at) begin
                value = lv;
                dp    = ldp;
                load  = 1'b1;
            end
        end
    endtask

    initial begin
        reset  = 1'b1;
        value  = '0;
        dp     = '0;
        load   = 1'b0;
        lz_en  = 1'b0;
        bright = 2'd3;
        #2 reset = 1'b0;
        #1;
        check("rst an", 32'(an), 32'hF);
        check("rst seg", 32'(seg), 32'hFF);
        check("rst tick", 32'(frame_tick), 32'h0);
        check("rst pending", 32'(pending), 32'h0);
        repeat (3) @(posedge ext_clk);
        #1 reset = 1'b1;

        scan_frame("f1_zero", 32'hC0C0C0C0, 4'hF, 3, 1'b0, -1, 16'h0, 4'h0);
        scan_frame("f2_load", 32'hC0C0C0C0, 4'hF, 3, 1'b0, 5, 16'h12AF, 4'b0100);
        check("f2 pending end", 32'(pending), 32'h0);
        scan_frame("f3_12af", 32'hF924888E, 4'hF, 3, 1'b1, 5, 16'h0005, 4'b0000);
        scan_frame("f4_lz5", 32'hC0C0C092, 4'b0001, 3, 1'b1, 5, 16'h0000, 4'b0000);
        scan_frame("f5_lz0", 32'hC0C0C0C0, 4'b0001, 3, 1'b1, 5, 16'h0000, 4'b1000);
        scan_frame("f6_lzdp", 32'h40C0C0C0, 4'b1001, 3, 1'b1, -1, 16'h0, 4'h0);
        scan_frame("f7_b0", 32'h40C0C0C0, 4'hF, 0, 1'b0, -1, 16'h0, 4'h0);
        scan_frame("f8_b1", 32'h40C0C0C0, 4'hF, 1, 1'b0, -1, 16'h0, 4'h0);
        scan_frame("f9_b2", 32'h40C0C0C0, 4'hF, 2, 1'b0, 14, 16'h8888, 4'h0);
        scan_frame("f10_8888", 32'h80808080, 4'hF, 3, 1'b0, -1, 16'h0, 4'h0);
        check("f10 pending", 32'(pending), 32'h0);

        for (int k = 1; k <= 10; k++) begin
            @(posedge ext_clk);
            #1;
            if (k == 2) begin
                value = 16'h1234;
                load  = 1'b1;
            end
            if (k == 3) load = 1'b0;
        end
        $display("pre-reset an=%h seg=%h pend=%b", an, seg, pending);
        check("mid an", 32'(an), 32'hB);
        check("mid seg", 32'(seg), 32'h80);
        check("mid pending", 32'(pending), 32'h1);
        reset = 1'b0;
        #1;
        $display("async reset an=%h seg=%h pend=%b", an, seg, pending);
        check("arst an", 32'(an), 32'hF);
        check("arst seg", 32'(seg), 32'hFF);
        check("arst pending", 32'(pending), 32'h0);
        check("arst tick", 32'(frame_tick), 32'h0);
        repeat (2) @(posedge ext_clk);
        #1;
        check("hold an", 32'(an), 32'hF);
        reset = 1'b1;
        scan_frame("f11_restart", 32'hC0C0C0C0, 4'hF, 3, 1'b0, -1, 16'h0, 4'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
